// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data mmu port arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM state encoding (2 bits).
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    // Grant IDs; also the bit index of each requester in the picker's req vector.
    localparam logic ARB_GNT_IF = 1'b0;
    localparam logic ARB_GNT_D  = 1'b1;

    // mmu access widths.
    localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MMU_WIDTH_WORD = 2'd3;

    // One latched access as presented to the mmu.
    typedef struct packed {
        logic        we;
        logic        sgn;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Fetches are always unsigned word reads; no store data is carried.
    function automatic mem_req_t fetch_req(input logic [31:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.sgn   = 1'b0;
        r.width = MMU_WIDTH_WORD;
        r.addr  = addr;
        r.wdata = 32'h0000_0000;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the mmu port seen by the arbiter.
interface mem_arbiter_if;

    // Instruction-fetch requester.
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    // Load/store requester.
    logic        d_req;
    logic        d_we;
    logic        d_signed;
    logic [1:0]  d_width;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    // Shared mmu port.
    logic        mmu_read_enable;
    logic        mmu_write_enable;
    logic        mmu_signed_read;
    logic [1:0]  mmu_data_width;
    logic [31:0] mmu_address;
    logic [31:0] mmu_data_in;
    logic [31:0] mmu_data_out;
    logic        mmu_ready;

    // Arbiter side: serves the requesters and drives the mmu.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_signed, d_width, d_addr, d_wdata,
        input  mmu_data_out, mmu_ready,
        output if_ack, if_rdata, if_err,
        output d_ack, d_rdata, d_err,
        output mmu_read_enable, mmu_write_enable, mmu_signed_read,
        output mmu_data_width, mmu_address, mmu_data_in
    );

    // Environment side: requesters plus the mmu itself.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_signed, d_width, d_addr, d_wdata,
        output mmu_data_out, mmu_ready,
        input  if_ack, if_rdata, if_err,
        input  d_ack, d_rdata, d_err,
        input  mmu_read_enable, mmu_write_enable, mmu_signed_read,
        input  mmu_data_width, mmu_address, mmu_data_in
    );

endinterface

// File: rtl/mem_arbiter_arb2_rr.sv
// Combinational two-way picker: fixed priority to requester 1, or alternate
// on ties when fair_i is set. Reusable for other two-master buses.
module arb2_rr
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,        // bit ARB_GNT_IF = fetch, bit ARB_GNT_D = data
    input  logic       last_grant_i,
    input  logic       fair_i,
    output logic       grant_o
);

    // Choose the winner; with no request the result is don't-care (data).
    always_comb begin
        grant_o = ARB_GNT_D;
        case (req_i)
            2'b01: grant_o = ARB_GNT_IF;
            2'b10: grant_o = ARB_GNT_D;
            2'b11: begin
                if (fair_i) begin
                    grant_o = ~last_grant_i;
                end else begin
                    grant_o = ARB_GNT_D;
                end
            end
            default: grant_o = ARB_GNT_D;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mmu port between instruction fetch and load/store. One access
// is outstanding at a time: grant, one-cycle enable pulse, wait for
// mem_ready (or timeout), then a one-cycle ack to the winner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int FAIR           = 1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
)
(
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                 FAIR_EN  = (FAIR != 0);

    arb_state_e             state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   gnt_q, gnt_d;
    mem_req_t               req_q, req_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   if_ack_q, if_ack_d;
    logic                   d_ack_q, d_ack_d;
    logic                   if_err_q, if_err_d;
    logic                   d_err_q, d_err_d;
    logic [31:0]            if_rdata_q, if_rdata_d;
    logic [31:0]            d_rdata_q, d_rdata_d;
    logic                   busy_q, busy_d;

    logic [1:0]             req_vec_s;
    logic                   pick_s;

    assign req_vec_s = {bus.d_req, bus.if_req};

    arb2_rr u_pick (
        .req_i        (req_vec_s),
        .last_grant_i (last_grant_q),
        .fair_i       (FAIR_EN),
        .grant_o      (pick_s)
    );

    // Next-state, request latch, timeout counter and response generation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_err_d     = if_err_q;
        d_err_d      = d_err_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (req_vec_s != 2'b00) begin
                    gnt_d        = pick_s;
                    last_grant_d = pick_s;
                    if (pick_s == ARB_GNT_IF) begin
                        req_d = fetch_req(bus.if_addr);
                    end else begin
                        req_d.we    = bus.d_we;
                        req_d.sgn   = bus.d_signed;
                        req_d.width = bus.d_width;
                        req_d.addr  = bus.d_addr;
                        req_d.wdata = bus.d_wdata;
                    end
                    // Enables are registered, so they are high exactly during ACCESS.
                    rd_en_d = ~req_d.we;
                    wr_en_d = req_d.we;
                    state_d = ARB_ACCESS;
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_ACCESS: begin
                cnt_d   = CNT_ZERO;
                state_d = ARB_WAIT;
            end

            ARB_WAIT: begin
                if (bus.mmu_ready) begin
                    if (gnt_q == ARB_GNT_IF) begin
                        if_rdata_d = bus.mmu_data_out;
                        if_err_d   = 1'b0;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d  = bus.mmu_data_out;
                        d_err_d    = 1'b0;
                        d_ack_d    = 1'b1;
                    end
                    state_d = ARB_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // mem_ready never came back: abort with zero data and err set.
                    if (gnt_q == ARB_GNT_IF) begin
                        if_rdata_d = 32'h0000_0000;
                        if_err_d   = 1'b1;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d  = 32'h0000_0000;
                        d_err_d    = 1'b1;
                        d_ack_d    = 1'b1;
                    end
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ARB_RESP: begin
                // Requests are ignored here so a late-dropping requester is not regranted.
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_GNT_D;
            gnt_q        <= ARB_GNT_IF;
            req_q.we     <= 1'b0;
            req_q.sgn    <= 1'b0;
            req_q.width  <= 2'd0;
            req_q.addr   <= 32'h0000_0000;
            req_q.wdata  <= 32'h0000_0000;
            cnt_q        <= CNT_ZERO;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_err_q     <= 1'b0;
            d_err_q      <= 1'b0;
            if_rdata_q   <= 32'h0000_0000;
            d_rdata_q    <= 32'h0000_0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_err_q     <= if_err_d;
            d_err_q      <= d_err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.if_ack           = if_ack_q;
    assign bus.if_rdata         = if_rdata_q;
    assign bus.if_err           = if_err_q;
    assign bus.d_ack            = d_ack_q;
    assign bus.d_rdata          = d_rdata_q;
    assign bus.d_err            = d_err_q;
    assign bus.mmu_read_enable  = rd_en_q;
    assign bus.mmu_write_enable = wr_en_q;
    assign bus.mmu_signed_read  = req_q.sgn;
    assign bus.mmu_data_width   = req_q.width;
    assign bus.mmu_address      = req_q.addr;
    assign bus.mmu_data_in      = req_q.wdata;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: FAIR=1 instance with a delay/stuck mmu model and a
// FAIR=0 instance with an always-ready mmu.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic busy1, busy0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter_if bus0();

    mem_arbiter #(.FAIR(1), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy1)
    );

    mem_arbiter #(.FAIR(0), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .busy(busy0)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents of the model mmu.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h00A0_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- mmu model for the FAIR=1 instance ----------------
    int   mmu_delay = 0;
    int   dly_cnt   = 0;
    logic mmu_stuck = 1'b0;
    int   rd_cnt    = 0;
    int   wr_cnt    = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            bus.mmu_data_out <= 32'h0;
            dly_cnt          <= 0;
        end else if (bus.mmu_read_enable) begin
            bus.mmu_data_out <= mem_word(bus.mmu_address);
            dly_cnt          <= mmu_delay;
        end else if (bus.mmu_write_enable) begin
            bus.mmu_data_out <= 32'h0;
            dly_cnt          <= mmu_delay;
        end else if (dly_cnt != 0) begin
            dly_cnt <= dly_cnt - 1;
        end
    end
    assign bus.mmu_ready = !mmu_stuck && (dly_cnt == 0);

    always @(negedge clk) begin
        if (bus.mmu_read_enable)  rd_cnt++;
        if (bus.mmu_write_enable) wr_cnt++;
    end

    // ---------------- mmu model for the FAIR=0 instance ----------------
    always @(posedge clk) begin
        if (!reset_n) bus0.mmu_data_out <= 32'h0;
        else if (bus0.mmu_read_enable) bus0.mmu_data_out <= mem_word(bus0.mmu_address);
    end
    assign bus0.mmu_ready = 1'b1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (bus.if_ack || bus.d_ack)) begin
            if (bus.if_ack && bus.d_ack) begin
                total++; bad++;
                $display("FAIL dual_ack: got both acks expected one");
            end else if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected none", bus.if_ack, bus.d_ack);
            end else begin
                e = sb_q.pop_front();
                check("sb_port", {31'b0, bus.d_ack}, {31'b0, e.port});
                check("sb_rdata", bus.d_ack ? bus.d_rdata : bus.if_rdata, e.rdata);
                check("sb_err", {31'b0, (bus.d_ack ? bus.d_err : bus.if_err)}, {31'b0, e.err});
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        port;
        logic        we;
        logic        sgn;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs[7];

    // Run one single-requester access; starts by syncing to a fresh cycle.
    task automatic run_vec(input vec_t v, input logic exp_err);
        int   lat = -1;
        logic addr_ok = 1'b1;
        logic ack;
        @(posedge clk); #1;
        mmu_delay = v.delay;
        rd_cnt = 0;
        wr_cnt = 0;
        sb_q.push_back('{v.port, v.exp_rdata, exp_err});
        if (v.port == ARB_GNT_IF) begin
            bus.if_addr = v.addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.d_we     = v.we;
            bus.d_signed = v.sgn;
            bus.d_width  = v.width;
            bus.d_addr   = v.addr;
            bus.d_wdata  = v.wdata;
            bus.d_req    = 1'b1;
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k >= 1 && bus.mmu_address !== v.addr) addr_ok = 1'b0;
            if (k == 1) begin
                bus.if_addr = 32'hDEAD_BEEF;
                bus.d_addr  = 32'hDEAD_BEEF;
                bus.d_wdata = ~v.wdata;
            end
            ack = (v.port == ARB_GNT_D) ? bus.d_ack : bus.if_ack;
            if (ack) begin
                lat = k;
                break;
            end
        end
        if (lat >= 0) begin
            check("mmu_width", {30'b0, bus.mmu_data_width}, {30'b0, v.width});
            check("mmu_signed", {31'b0, bus.mmu_signed_read}, {31'b0, v.sgn});
            check("busy_at_ack", {31'b0, busy1}, 32'd1);
            if (v.port == ARB_GNT_D) check("mmu_data_in", bus.mmu_data_in, v.wdata);
        end
        check("ack_latency", 32'(lat), 32'(v.exp_lat));
        check("addr_stable", {31'b0, addr_ok}, 32'd1);
        check("rd_pulses", 32'(rd_cnt), v.we ? 32'd0 : 32'd1);
        check("wr_pulses", 32'(wr_cnt), v.we ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        check("busy_after", {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int  if_k, d_k, dcnt, dcnt_at_if;
        logic got_if, got_d;
        logic [31:0] if_rd;

        vecs[0] = '{ARB_GNT_IF, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0000_0008, 32'h0, 0, 32'h00A0_0093, 3};
        vecs[1] = '{ARB_GNT_D,  1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0100_0004, 32'h1234_5678, 0, 32'h0004_FFFB, 3};
        vecs[2] = '{ARB_GNT_D,  1'b1, 1'b0, MMU_WIDTH_BYTE, 32'h0100_0002, 32'h0000_00AB, 2, 32'h0, 5};
        vecs[3] = '{ARB_GNT_D,  1'b0, 1'b1, MMU_WIDTH_HALF, 32'h0100_0010, 32'h0, 1, 32'h0010_FFEF, 4};
        vecs[4] = '{ARB_GNT_IF, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0000_0100, 32'h0, 3, 32'h0100_FEFF, 6};
        vecs[5] = '{ARB_GNT_D,  1'b0, 1'b0, MMU_WIDTH_BYTE, 32'h0100_0021, 32'h0, 0, 32'h0021_FFDE, 3};
        vecs[6] = '{ARB_GNT_D,  1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0100_0040, 32'h0, 15, 32'h0040_FFBF, 18};

        // Reset with both requests already pending.
        reset_n      = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0008;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_signed = 1'b0;
        bus.d_width  = MMU_WIDTH_WORD;
        bus.d_addr   = 32'h0100_0004;
        bus.d_wdata  = 32'h0;
        bus0.if_req = 1'b0; bus0.if_addr = 32'h0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_signed = 1'b0; bus0.d_width = 2'd0; bus0.d_addr = 32'h0; bus0.d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy1}, 32'd0);
        check("rst_acks_errs", {28'b0, bus.if_ack, bus.d_ack, bus.if_err, bus.d_err}, 32'd0);
        check("rst_enables", {30'b0, bus.mmu_read_enable, bus.mmu_write_enable}, 32'd0);
        check("rst_addr", bus.mmu_address, 32'd0);
        check("rst_data_in", bus.mmu_data_in, 32'd0);
        check("rst_width", {30'b0, bus.mmu_data_width}, 32'd0);
        check("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);

        // Tie from reset under FAIR=1: fetch first, data 4 cycles later.
        sb_q.push_back('{ARB_GNT_IF, 32'h00A0_0093, 1'b0});
        sb_q.push_back('{ARB_GNT_D,  32'h0004_FFFB, 1'b0});
        @(posedge clk); #1;
        reset_n = 1'b1;
        got_if = 1'b0; got_d = 1'b0; if_k = -1; d_k = -1;
        for (int k = 0; k < 40 && !(got_if && got_d); k++) begin
            @(negedge clk);
            if (bus.if_ack && !got_if) begin got_if = 1'b1; if_k = k; end
            if (bus.d_ack && !got_d)   begin got_d  = 1'b1; d_k  = k; end
            @(posedge clk); #1;
            if (got_if) bus.if_req = 1'b0;
            if (got_d)  bus.d_req  = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        check("tie_if_lat", 32'(if_k), 32'd3);
        check("tie_d_lat", 32'(d_k), 32'd7);

        // Table-driven single accesses.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

        // Timeout: mem_ready never returns.
        mmu_stuck = 1'b1;
        run_vec('{ARB_GNT_D, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0100_0080, 32'h0, 0, 32'h0, 18}, 1'b1);
        mmu_stuck = 1'b0;

        // Reset in the middle of WAIT: access abandoned, no ack.
        mmu_stuck = 1'b1;
        @(posedge clk); #1;
        bus.d_we = 1'b0; bus.d_width = MMU_WIDTH_WORD; bus.d_addr = 32'h0100_0100; bus.d_req = 1'b1;
        repeat (4) @(negedge clk);
        check("midwait_busy", {31'b0, busy1}, 32'd1);
        @(posedge clk); #1;
        reset_n   = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        mmu_stuck = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy1}, 32'd0);
        check("midrst_enables", {30'b0, bus.mmu_read_enable, bus.mmu_write_enable}, 32'd0);
        check("midrst_acks", {30'b0, bus.if_ack, bus.d_ack}, 32'd0);
        check("midrst_addr", bus.mmu_address, 32'd0);
        repeat (4) @(negedge clk);
        check("midrst_idle", {31'b0, busy1}, 32'd0);

        // FAIR=0 instance: data wins every tie while both are held.
        @(posedge clk); #1;
        bus0.if_addr = 32'h0000_0008; bus0.if_req = 1'b1;
        bus0.d_addr = 32'h0100_0004; bus0.d_width = MMU_WIDTH_WORD; bus0.d_req = 1'b1;
        dcnt = 0; dcnt_at_if = -1; if_k = -1; if_rd = 32'h0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus0.d_ack) begin
                dcnt++;
                check("fair0_d_rdata", bus0.d_rdata, 32'h0004_FFFB);
            end
            if (bus0.if_ack) begin
                if_k = k; dcnt_at_if = dcnt; if_rd = bus0.if_rdata;
                break;
            end
            @(posedge clk); #1;
            if (dcnt == 3) bus0.d_req = 1'b0;
        end
        @(posedge clk); #1;
        bus0.if_req = 1'b0;
        bus0.d_req  = 1'b0;
        check("fair0_d_first", 32'(dcnt_at_if), 32'd3);
        check("fair0_if_lat", 32'(if_k), 32'd15);
        check("fair0_if_rdata", if_rd, 32'h00A0_0093);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single mmu port between the instruction-fetch requester and the load/store requester.
- Each request is latched and driven to the mmu as a one-cycle enable pulse, with address, data, width and sign held stable.
- Completion is detected from mmu mem_ready; read data and a one-cycle ack are returned to the winning requester.
- Provides fixed-priority or round-robin arbitration, plus a timeout that aborts an access whose mem_ready never returns.

Parameters:
- FAIR, 1: 1 = round-robin on simultaneous requests; 0 = data port always wins.
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before an access is aborted; must be >= 2.
- CNT_WIDTH, 5: timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- if_req  in  1  fetch request, held high until if_ack
- if_addr  in  32  fetch address (word read, unsigned)
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word, valid while if_ack=1
- if_err  out  1  timeout flag, valid while if_ack=1
- d_req  in  1  data request, held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_signed  in  1  signed load
- d_width  in  2  0 byte, 1 half, 3 word (`MMU_WIDTH_WORD)
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  load data, valid while d_ack=1
- d_err  out  1  timeout flag, valid while d_ack=1
- mmu_read_enable  out  1  to mmu read_enable
- mmu_write_enable  out  1  to mmu write_enable
- mmu_signed_read  out  1  to mmu mem_signed_read
- mmu_data_width  out  2  to mmu mem_data_width
- mmu_address  out  32  to mmu address
- mmu_data_in  out  32  to mmu data_in
- mmu_data_out  in  32  from mmu data_out
- mmu_ready  in  1  from mmu mem_ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; all acks, errs and enables are 0; rdata, address, data_in and width registers are 0.
  - last_grant=DATA, so fetch wins the first tie when FAIR=1.
  - Reset overrides any in-flight access; no ack is issued for it.
- IDLE:
  - If neither request is high, stay in IDLE.
  - With one request high, grant it. With both high: FAIR=0 grants data; FAIR=1 grants the port not equal to last_grant.
  - On grant, latch addr/wdata/we/signed/width into the request registers. Fetch latches we=0, signed=0, width=`MMU_WIDTH_WORD.
  - Update last_grant and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mmu_read_enable = !we_q, mmu_write_enable = we_q.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Enables are 0; address, data_in, width and signed are held from the latch.
  - If mmu_ready=1: capture mmu_data_out into the granted port's rdata, err=0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rdata=0, err=1, go to RESP.
  - Else increment the counter.
  - The first WAIT cycle sees the 1-cycle ROM/RAM read data when mmu_ready stayed high.
- RESP (1 cycle):
  - The granted port's ack=1 with rdata/err valid; the other port's ack=0.
  - Requests are ignored this cycle, so a requester dropping req late is never regranted.
  - Go to IDLE.
- Latency: minimum 3 cycles from req sampled in IDLE to ack (IDLE, ACCESS, WAIT, then ack in RESP). Multi-cycle mmu operations add the cycles mem_ready is low.
- mmu outputs hold their last values in IDLE; the enables are 0.
- A requester changing addr/data while waiting has no effect; values are latched at grant.
- Back-to-back: a request held through RESP is regranted in the next IDLE cycle, so the minimum spacing is 4 cycles per access.
- The port not granted keeps waiting with no ack; no request is dropped.
- Only one access is outstanding at a time.

Decomposition:
- define.v gains:
  - state encodings `ARB_IDLE/ACCESS/WAIT/RESP (2 bits);
  - grant IDs `ARB_GNT_IF=0, `ARB_GNT_D=1;
  - `MMU_WIDTH_BYTE/HALF alongside `MMU_WIDTH_WORD.
- One sub-module: arb2_rr, the combinational 2-way picker (inputs req[1:0], last_grant, fair; output grant). It is reused later for peripheral bus sharing.
- The FSM, latches and timeout counter stay in mem_arbiter.

Test Plan:
- Fetch read: if_req=1, if_addr=0x00000008, mmu returns 0x00A00093 with ready held high. Required: if_ack at cycle 3, if_rdata=0x00A00093, if_err=0.
- Simultaneous requests, FAIR=1: if_req and d_req (load 0x01000004) both high from reset. Required: fetch acked first. Data is granted in the next IDLE and acked 4 cycles after if_ack.
- FAIR=0, both requests held continuously for 3 accesses. Required: three d_acks before any if_ack.
- Byte store: d_we=1, d_width=0, d_addr=0x01000002, d_wdata=0xAB; model mmu drops ready for 2 cycles. Required: write_enable pulses for exactly 1 cycle, address stays stable, d_ack at cycle 5, d_err=0.
- Timeout: mmu_ready stuck at 0. Required: d_ack with d_err=1 and d_rdata=0 after TIMEOUT_CYCLES WAIT cycles, then busy=0 the cycle after.
- Mid-WAIT reset and late drop: reset_n=0 for 1 cycle during WAIT gives state IDLE, no ack, all enables 0. Separately, req still high during the RESP cycle produces no extra grant.
